env_sweep_scheduler: RTL and testbench
======================================

Name: env_sweep_scheduler

Overview:
Sequences the per-generation environment update. On each game tick it walks the write location over every grid cell in raster order. At each cell it waits for the environment lookup and env_cache to settle, then pulses write_flag for exactly one cycle. It replaces free-running location stepping during RUN, and it owns hold_locs, pause handling and tick-overrun accounting.

Parameters:
GRID_W, 160, cells per row (render width 640 >> 2)
GRID_H, 120, rows (render height 480 >> 2)
X_BITS, 8, width of writeLoc_x; must satisfy 2^X_BITS >= GRID_W
Y_BITS, 7, width of writeLoc_y; must satisfy 2^Y_BITS >= GRID_H
SETTLE_CYCLES, 2, cycles the address is held before the write; legal range 1..15
MISS_BITS, 8, width of the missed-tick counter

Ports:
newLocClock  in  1  the single clock for the block
RESET_SIM  in  1  synchronous, active-high reset
RUN  in  1  simulation running (~SETUP_MODE); low forces IDLE
game_clk  in  1  slow level clock from clock_cutter; its rising edge is detected internally
KEY_PAUSE  in  1  active-low pause button, raw level
writeLoc_x  out  X_BITS  current cell column
writeLoc_y  out  Y_BITS  current cell row
write_flag  out  1  one-cycle commit strobe for the current cell
hold_locs  out  1  high while the location counters must not free-run
busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse after the last cell is written
missed_ticks  out  MISS_BITS  saturating count of ticks dropped while busy

Behaviour:
- Reset: state=IDLE; all outputs 0 except hold_locs=1; tick and pause synchroniser flops are cleared.
- Tick detect: game_clk passes through 2 flops. tick = sync & ~sync_d. KEY_PAUSE passes through a 2-flop synchroniser; paused = ~sync.
- States: IDLE, SETTLE, WRITE, STALL, DONE.
- IDLE: x=y=0, busy=0. If tick & RUN & ~paused, go to SETTLE and set busy=1 in the next cycle. A tick arriving while paused or with RUN=0 is discarded and not counted.
- SETTLE: a settle counter counts 0..SETTLE_CYCLES-1 with the address stable. Then go to WRITE.
- WRITE: write_flag=1 for this one cycle only; the address is unchanged during this cycle.
  - Last cell (x=GRID_W-1, y=GRID_H-1): go to DONE.
  - Otherwise advance: x+1. When x reaches GRID_W-1, x wraps to 0 and y increments.
  - Then: if paused, go to STALL; otherwise go to SETTLE with the settle counter reset.
- STALL: hold the address, write_flag=0. When unpaused, go to SETTLE with a full settle period. A pause never splits a cell, so the write for the current cell completes first.
- DONE: sweep_done=1 for one cycle; busy drops; x=y=0; go to IDLE.
- Cost per cell: SETTLE_CYCLES+1 cycles. Sweep length: GRID_W*GRID_H*(SETTLE_CYCLES+1) cycles with no pause.
- Overrun: a tick seen in any state other than IDLE increments missed_ticks, saturating at all-ones. It does not restart the sweep. A tick in the DONE cycle also counts.
- RUN falling mid-sweep: go to IDLE the next cycle, with no write and no sweep_done. Address returns to 0. missed_ticks is kept.
- hold_locs = 1 in every state; the location modules must never free-run while this block drives them.
- RESET_SIM mid-sweep: same as reset. missed_ticks clears.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared params package: X_bits, Y_bits, GRID_W/GRID_H constants, and typedef enum sweep_state_t {IDLE, SETTLE, WRITE, STALL, DONE}.
- One natural sub-module: edge_sync, a 2-flop synchroniser plus rising-edge detect. It is instantiated for game_clk; the same synchroniser without edge detect is used for KEY_PAUSE.

Test Plan (GRID_W=4, GRID_H=3, SETTLE_CYCLES=2 unless noted):
1. Reset then one tick with RUN=1: expect 12 write_flag pulses, each 3 cycles apart, with addresses (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2). sweep_done pulses one cycle after the (3,2) write; busy is high for exactly 36 cycles plus the DONE cycle.
2. Second tick injected at cell 5: missed_ticks=1 and the sweep completes unchanged. Inject 300 ticks with MISS_BITS=8: missed_ticks saturates at 255.
3. Assert pause during SETTLE of cell (1,0): the (1,0) write still occurs, then the block stalls at (2,0) with no write_flag. Release pause: the (2,0) write lands exactly 3 cycles later.
4. Tick with RUN=0, or tick while paused in IDLE: the block stays IDLE, write_flag never asserts, and missed_ticks stays 0.
5. Drop RUN at cell 7: next cycle is IDLE at (0,0); no further writes and no sweep_done.
6. Assert RESET_SIM at cell 4: all outputs return to reset values the next cycle and missed_ticks=0. A fresh tick restarts the sweep at (0,0).

Source files
------------

// File: rtl/env_sweep_scheduler_pkg.sv
// Shared constants and state type for the environment sweep scheduler.
// Defaults describe the 160x120 cell grid (640x480 render >> 2).
package env_sweep_scheduler_pkg;

  localparam int GRID_W_DEF   = 160;
  localparam int GRID_H_DEF   = 120;
  localparam int X_BITS_DEF   = 8;
  localparam int Y_BITS_DEF   = 7;
  localparam int SETTLE_DEF   = 2;
  localparam int MISS_BITS_DEF = 8;
  // settle counter is sized for the largest legal settle period (15)
  localparam int CNT_BITS     = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WRITE,
    STALL,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/env_sweep_scheduler_edge_sync.sv
// Two-flop synchroniser with optional rising-edge detect.
// Ports:
//   i_clk  - block clock
//   i_rst  - synchronous active-high reset, clears all flops
//   i_d    - asynchronous level input
//   o_sync - synchronised level
//   o_rise - one-cycle pulse on a synchronised 0->1 (0 when EDGE_DET=0)
module env_sweep_scheduler_edge_sync #(
  parameter bit EDGE_DET = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

  generate
    if (EDGE_DET) begin : g_edge
      logic r_sync_d;
      always_ff @(posedge i_clk) begin
        if (i_rst) r_sync_d <= 1'b0;
        else       r_sync_d <= r_sync;
      end
      assign o_rise = r_sync & ~r_sync_d;
    end else begin : g_level
      assign o_rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/env_sweep_scheduler.sv
// Per-generation environment sweep: on each game tick, walks the write
// location over every grid cell in raster order, holds each address for
// SETTLE_CYCLES, then strobes write_flag for one cycle.
// Ports:
//   newLocClock  - block clock
//   RESET_SIM    - synchronous active-high reset
//   RUN          - simulation running; low aborts to IDLE
//   game_clk     - slow tick level; rising edge starts a sweep
//   KEY_PAUSE    - active-low pause button (raw)
//   writeLoc_x/y - current cell address
//   write_flag   - one-cycle commit strobe for the current cell
//   hold_locs    - constant 1: location counters never free-run
//   busy         - sweep in progress (including the DONE cycle)
//   sweep_done   - one-cycle pulse after the last cell is written
//   missed_ticks - saturating count of ticks seen outside IDLE
module env_sweep_scheduler
  import env_sweep_scheduler_pkg::*;
#(
  parameter int GRID_W        = GRID_W_DEF,
  parameter int GRID_H        = GRID_H_DEF,
  parameter int X_BITS        = X_BITS_DEF,
  parameter int Y_BITS        = Y_BITS_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF,
  parameter int MISS_BITS     = MISS_BITS_DEF
) (
  input  logic                 newLocClock,
  input  logic                 RESET_SIM,
  input  logic                 RUN,
  input  logic                 game_clk,
  input  logic                 KEY_PAUSE,
  output logic [X_BITS-1:0]    writeLoc_x,
  output logic [Y_BITS-1:0]    writeLoc_y,
  output logic                 write_flag,
  output logic                 hold_locs,
  output logic                 busy,
  output logic                 sweep_done,
  output logic [MISS_BITS-1:0] missed_ticks
);

  sweep_state_t          r_state, w_state_nxt;
  logic [CNT_BITS-1:0]   r_cnt, w_cnt_nxt;
  logic [X_BITS-1:0]     r_x, w_x_nxt;
  logic [Y_BITS-1:0]     r_y, w_y_nxt;
  logic                  r_write, r_busy, r_done;
  logic [MISS_BITS-1:0]  r_missed;

  logic w_tick, w_game_sync_unused;
  logic w_pause_sync, w_pause_rise_unused;
  logic w_paused, w_last;

  env_sweep_scheduler_edge_sync #(.EDGE_DET(1'b1)) u_tick_sync (
    .i_clk  (newLocClock),
    .i_rst  (RESET_SIM),
    .i_d    (game_clk),
    .o_sync (w_game_sync_unused),
    .o_rise (w_tick)
  );

  env_sweep_scheduler_edge_sync #(.EDGE_DET(1'b0)) u_pause_sync (
    .i_clk  (newLocClock),
    .i_rst  (RESET_SIM),
    .i_d    (KEY_PAUSE),
    .o_sync (w_pause_sync),
    .o_rise (w_pause_rise_unused)
  );

  // synchroniser clears to 0, so the block reads as paused until the
  // released button has propagated after reset
  assign w_paused = ~w_pause_sync;
  assign w_last   = (r_x == X_BITS'(GRID_W - 1)) && (r_y == Y_BITS'(GRID_H - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    if (!RUN) begin
      // abort: no write, no done pulse, address back to origin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_x_nxt = '0;
          w_y_nxt = '0;
          if (w_tick && !w_paused) begin
            w_state_nxt = SETTLE;
            w_cnt_nxt   = '0;
          end
        end
        SETTLE: begin
          if (r_cnt == CNT_BITS'(SETTLE_CYCLES - 1)) w_state_nxt = WRITE;
          else                                       w_cnt_nxt   = r_cnt + 1'b1;
        end
        WRITE: begin
          if (w_last) begin
            w_state_nxt = DONE;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
          end else begin
            if (r_x == X_BITS'(GRID_W - 1)) begin
              w_x_nxt = '0;
              w_y_nxt = r_y + 1'b1;
            end else begin
              w_x_nxt = r_x + 1'b1;
            end
            // pause is honoured only between cells so a write is never split
            if (w_paused) begin
              w_state_nxt = STALL;
            end else begin
              w_state_nxt = SETTLE;
              w_cnt_nxt   = '0;
            end
          end
        end
        STALL: begin
          if (!w_paused) begin
            w_state_nxt = SETTLE;
            w_cnt_nxt   = '0;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // status outputs are registered from the next state so they line up
  // exactly with the state they describe
  always_ff @(posedge newLocClock) begin
    if (RESET_SIM) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_write  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_missed <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_write <= (w_state_nxt == WRITE);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
      if (w_tick && (r_state != IDLE) && (r_missed != '1))
        r_missed <= r_missed + 1'b1;
    end
  end

  assign writeLoc_x   = r_x;
  assign writeLoc_y   = r_y;
  assign write_flag   = r_write;
  assign hold_locs    = 1'b1;
  assign busy         = r_busy;
  assign sweep_done   = r_done;
  assign missed_ticks = r_missed;

endmodule

// File: tb/tb_env_sweep_scheduler.sv
// Scoreboard bench for env_sweep_scheduler on a 4x3 grid, settle 2.
// Expected writes (cell, cycle) are queued when stimulus is issued; a
// forked monitor pops and compares whenever write_flag / sweep_done fire.
module tb_env_sweep_scheduler;

  localparam int GW  = 4;
  localparam int GH  = 3;
  localparam int S   = 2;
  localparam int XB  = 8;
  localparam int YB  = 7;
  localparam int MB  = 8;
  localparam int N   = GW * GH;
  localparam int CPC = S + 1;       // cycles per cell
  localparam int LAT = 3 + S;       // tick rise to first write: 2 sync + IDLE exit + settle

  logic          clk = 1'b0;
  logic          rst, run, gclk_in, key_n;
  logic [XB-1:0] wx;
  logic [YB-1:0] wy;
  logic          wf, hold, busy, done;
  logic [MB-1:0] missed;

  env_sweep_scheduler #(
    .GRID_W(GW), .GRID_H(GH), .X_BITS(XB), .Y_BITS(YB),
    .SETTLE_CYCLES(S), .MISS_BITS(MB)
  ) dut (
    .newLocClock (clk),
    .RESET_SIM   (rst),
    .RUN         (run),
    .game_clk    (gclk_in),
    .KEY_PAUSE   (key_n),
    .writeLoc_x  (wx),
    .writeLoc_y  (wy),
    .write_flag  (wf),
    .hold_locs   (hold),
    .busy        (busy),
    .sweep_done  (done),
    .missed_ticks(missed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int x; int y; int t;} wr_t;
  wr_t wr_q[$];
  int  done_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_wr  = 1'b1;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // raise game_clk for 3 cycles; c is the cycle in which it went high
  task automatic tick(output int c);
    @(negedge clk);
    c = cyc;
    gclk_in = 1'b1;
    step(3);
    gclk_in = 1'b0;
  endtask

  // cells k0..k1 in raster order, first one written at cycle base
  task automatic push_cells(int base, int k0, int k1);
    for (int k = k0; k <= k1; k++)
      wr_q.push_back('{k % GW, k / GW, base + (k - k0) * CPC});
  endtask

  task automatic check_drained(string tag);
    check({tag, "_writes_left"}, wr_q.size(), 0);
    check({tag, "_done_left"}, done_q.size(), 0);
  endtask

  task automatic monitor();
    wr_t e;
    int  t;
    forever begin
      @(negedge clk);
      check("hold_locs", int'(hold), 1);
      if (chk_wr && wf) begin
        if (wr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL wr_unexpected: write at (%0d,%0d) cycle %0d, expected none", wx, wy, cyc);
        end else begin
          e = wr_q.pop_front();
          check("wr_x", int'(wx), e.x);
          check("wr_y", int'(wy), e.y);
          check("wr_cycle", cyc, e.t);
        end
      end
      if (chk_wr && done) begin
        if (done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_unexpected: sweep_done at cycle %0d, expected none", cyc);
        end else begin
          t = done_q.pop_front();
          check("done_cycle", cyc, t);
        end
      end
    end
  endtask

  initial begin
    int c, c2, w0, bcnt, r;
    rst = 1'b1; run = 1'b1; gclk_in = 1'b0; key_n = 1'b1;
    fork monitor(); join_none
    fork begin
      #2000000;
      $display("FAIL watchdog: run did not finish, expected completion");
      $fatal(1, "watchdog");
    end join_none

    step(3);
    check("rst_x", int'(wx), 0);
    check("rst_y", int'(wy), 0);
    check("rst_wf", int'(wf), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_missed", int'(missed), 0);
    check("rst_hold", int'(hold), 1);
    rst = 1'b0;
    step(4);

    // ticks with RUN low, then while paused: discarded, not counted
    run = 1'b0;
    tick(c); step(8);
    check("runlow_busy", int'(busy), 0);
    check("runlow_missed", int'(missed), 0);
    run = 1'b1;
    key_n = 1'b0; step(4);
    tick(c); step(8);
    check("paused_busy", int'(busy), 0);
    check("paused_missed", int'(missed), 0);
    key_n = 1'b1; step(4);

    // full sweep, count busy cycles
    step($urandom_range(0, 5));
    tick(c);
    push_cells(c + LAT, 0, N - 1);
    done_q.push_back(c + LAT + (N - 1) * CPC + 1);
    bcnt = 0;
    repeat (N * CPC + 12) begin
      if (busy) bcnt++;
      step(1);
    end
    check("busy_cycles", bcnt, N * CPC + 1);
    check_drained("sweep1");
    check("sweep1_missed", int'(missed), 0);

    // second tick during cell 5 counts once and leaves the sweep untouched
    step($urandom_range(1, 6));
    tick(c);
    w0 = c + LAT;
    push_cells(w0, 0, N - 1);
    done_q.push_back(w0 + (N - 1) * CPC + 1);
    wait_cyc(w0 + 5 * CPC - 1);
    tick(c2);
    wait_cyc(w0 + N * CPC + 4);
    check("overrun_missed", int'(missed), 1);
    check_drained("overrun");

    // pause during settle of (1,0): that write lands, then stall at (2,0)
    step($urandom_range(1, 6));
    tick(c);
    w0 = c + LAT;
    push_cells(w0, 0, 1);
    wait_cyc(w0);
    key_n = 1'b0;
    wait_cyc(w0 + CPC + 1);
    check("stall_x", int'(wx), 2);
    check("stall_y", int'(wy), 0);
    check("stall_busy", int'(busy), 1);
    wait_cyc(w0 + CPC + 1 + $urandom_range(1, 15));
    r = cyc;
    key_n = 1'b1;
    push_cells(r + 2 + CPC, 2, N - 1);
    done_q.push_back(r + 2 + CPC + (N - 3) * CPC + 1);
    wait_cyc(r + 2 + N * CPC + 4);
    check_drained("pause");
    check("pause_missed", int'(missed), 1);

    // RUN drops while cell 7 is settling
    step($urandom_range(1, 6));
    tick(c);
    w0 = c + LAT;
    push_cells(w0, 0, 6);
    wait_cyc(w0 + 6 * CPC + 1);
    run = 1'b0;
    step(1);
    check("abort_busy", int'(busy), 0);
    check("abort_x", int'(wx), 0);
    check("abort_y", int'(wy), 0);
    check("abort_wf", int'(wf), 0);
    step(N * CPC + 4);
    check_drained("abort");
    check("abort_missed_kept", int'(missed), 1);
    run = 1'b1;
    step(2);

    // RESET_SIM while cell 4 is settling, then a fresh sweep
    tick(c);
    w0 = c + LAT;
    push_cells(w0, 0, 3);
    wait_cyc(w0 + 1);
    tick(c2);
    wait_cyc(w0 + 3 * CPC);
    check("pre_reset_missed", int'(missed), 2);
    wait_cyc(w0 + 3 * CPC + 1);
    rst = 1'b1;
    step(1);
    check("mid_rst_x", int'(wx), 0);
    check("mid_rst_y", int'(wy), 0);
    check("mid_rst_wf", int'(wf), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_missed", int'(missed), 0);
    rst = 1'b0;
    step(5);
    tick(c);
    push_cells(c + LAT, 0, N - 1);
    done_q.push_back(c + LAT + (N - 1) * CPC + 1);
    wait_cyc(c + LAT + N * CPC + 4);
    check_drained("restart");
    check("restart_missed", int'(missed), 0);

    // 300 ticks, one every 2 cycles: well over 255 land while busy
    chk_wr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); gclk_in = 1'b1;
      @(negedge clk); gclk_in = 1'b0;
    end
    run = 1'b0;
    step(5);
    check("sat_missed", int'(missed), (1 << MB) - 1);
    check("sat_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
